// File: rtl/rob_ctrl.sv
// Reorder-buffer head/tail/count controller: in-order multi-lane allocation, in-order prefix retire, flush.
// Optional performance counters are built only when ROB_CTRL_PERF_EN is defined; otherwise they read as 0.
module rob_ctrl #(
  parameter int MACHINE_WIDTH = 2,
  parameter int ROB_DEPTH     = 32,
  parameter int ROB_ADDR_W    = $clog2(ROB_DEPTH)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [MACHINE_WIDTH-1:0]               alloc_req,
  output logic                                   alloc_ok,
  output logic [MACHINE_WIDTH-1:0][ROB_ADDR_W-1:0] alloc_addr,
  output logic [MACHINE_WIDTH-1:0][ROB_ADDR_W-1:0] head_addr,
  input  logic [MACHINE_WIDTH-1:0]               head_done,
  output logic [MACHINE_WIDTH-1:0]               retire,
  input  logic                                   flush,
  output logic [ROB_ADDR_W:0]                    count,
  output logic                                   full,
  output logic                                   empty,
  output logic [31:0]                            perf_alloc_stall,
  output logic [31:0]                            perf_retired
);

  localparam int CW = ROB_ADDR_W + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(ROB_DEPTH);

  logic [ROB_ADDR_W-1:0] head;
  logic [ROB_ADDR_W-1:0] tail;
  logic [CW-1:0]         n_req;
  logic [CW-1:0]         n_ret;
  logic [ROB_ADDR_W-1:0] lane_off;
  logic                  prev_ret;

  // Requesting lanes are compacted onto consecutive entries starting at tail.
  always_comb begin
    n_req    = '0;
    lane_off = '0;
    for (int i = 0; i < MACHINE_WIDTH; i++) begin
      alloc_addr[i] = tail + lane_off;
      lane_off      = lane_off + ROB_ADDR_W'(alloc_req[i]);
      n_req         = n_req + CW'(alloc_req[i]);
    end
  end

  assign alloc_ok = !flush && ((DEPTH_C - count) >= n_req);

  always_comb begin
    n_ret    = '0;
    prev_ret = 1'b1;
    for (int i = 0; i < MACHINE_WIDTH; i++) begin
      head_addr[i] = head + ROB_ADDR_W'(i);
      retire[i]    = !flush && head_done[i] && (CW'(i) < count) && prev_ret;
      prev_ret     = retire[i];
      n_ret        = n_ret + CW'(retire[i]);
    end
  end

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (alloc_ok) tail <= tail + n_req[ROB_ADDR_W-1:0];
      head  <= head + n_ret[ROB_ADDR_W-1:0];
      count <= count + (alloc_ok ? n_req : '0) - n_ret;
    end
  end

`ifdef ROB_CTRL_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] retired_q;
  logic [32:0] retired_sum;

  assign retired_sum = {1'b0, retired_q} + 33'(n_ret);

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q   <= '0;
      retired_q <= '0;
    end else begin
      if ((|alloc_req) && !alloc_ok && !flush && (stall_q != '1))
        stall_q <= stall_q + 32'd1;
      retired_q <= retired_sum[32] ? '1 : retired_sum[31:0];
    end
  end

  assign perf_alloc_stall = stall_q;
  assign perf_retired     = retired_q;
`else
  assign perf_alloc_stall = '0;
  assign perf_retired     = '0;
`endif

endmodule

// File: tb/tb_rob_ctrl.sv
// Randomised check of rob_ctrl (2 lanes, 8 entries) against an occupancy-level reference model.
module tb_rob_ctrl;

  localparam int MW = 2;
  localparam int DEPTH = 8;
  localparam int AW = 3;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [MW-1:0]          alloc_req = '0;
  logic                   alloc_ok;
  logic [MW-1:0][AW-1:0]  alloc_addr;
  logic [MW-1:0][AW-1:0]  head_addr;
  logic [MW-1:0]          head_done = '0;
  logic [MW-1:0]          retire;
  logic                   flush = 1'b0;
  logic [AW:0]            count;
  logic                   full;
  logic                   empty;
  logic [31:0]            perf_alloc_stall;
  logic [31:0]            perf_retired;

  int checks = 0;
  int failures = 0;

  // reference state: oldest entry and occupancy; tail follows from them
  int m_head = 0;
  int m_count = 0;
  longint m_stall = 0;
  longint m_ret = 0;

  rob_ctrl #(.MACHINE_WIDTH(MW), .ROB_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .alloc_req(alloc_req), .alloc_ok(alloc_ok),
    .alloc_addr(alloc_addr), .head_addr(head_addr), .head_done(head_done),
    .retire(retire), .flush(flush), .count(count), .full(full), .empty(empty),
    .perf_alloc_stall(perf_alloc_stall), .perf_retired(perf_retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic [1:0] req, input logic [1:0] done, input logic fl, input logic rst);
    int tail, nreq, k, nret;
    logic ok, live;
    logic [1:0] eret;
    @(negedge clk);
    alloc_req = req; head_done = done; flush = fl; reset = rst;
    #1;
    tail = (m_head + m_count) % DEPTH;
    nreq = $countones(req);
    ok   = !fl && ((DEPTH - m_count) >= nreq);
    chk("alloc_ok", 32'(alloc_ok), 32'(ok));
    k = 0;
    for (int i = 0; i < MW; i++) begin
      if (req[i]) begin
        chk("alloc_addr", 32'(alloc_addr[i]), 32'((tail + k) % DEPTH));
        k++;
      end
      chk("head_addr", 32'(head_addr[i]), 32'((m_head + i) % DEPTH));
    end
    eret = '0; nret = 0; live = !fl;
    for (int i = 0; i < MW; i++) begin
      if (live && done[i] && (i < m_count)) begin
        eret[i] = 1'b1;
        nret++;
      end else live = 1'b0;
    end
    chk("retire", 32'(retire), 32'(eret));
    chk("count", 32'(count), 32'(m_count));
    chk("full", 32'(full), 32'(m_count == DEPTH));
    chk("empty", 32'(empty), 32'(m_count == 0));
`ifdef ROB_CTRL_PERF_EN
    chk("perf_alloc_stall", perf_alloc_stall, 32'(m_stall));
    chk("perf_retired", perf_retired, 32'(m_ret));
`else
    chk("perf_alloc_stall", perf_alloc_stall, 32'd0);
    chk("perf_retired", perf_retired, 32'd0);
`endif
    @(posedge clk);
    if (rst) begin
      m_head = 0; m_count = 0; m_stall = 0; m_ret = 0;
    end else begin
      if (req != 0 && !ok && !fl) m_stall++;
      m_ret += nret;
      if (fl) begin
        m_head = 0; m_count = 0;
      end else begin
        m_head  = (m_head + nret) % DEPTH;
        m_count = m_count + (ok ? nreq : 0) - nret;
      end
    end
  endtask

  initial begin
    step(2'b00, 2'b00, 1'b0, 1'b1);
    step(2'b11, 2'b11, 1'b1, 1'b1);
    // fill, then a refused request
    repeat (4) step(2'b11, 2'b00, 1'b0, 1'b0);
    step(2'b11, 2'b00, 1'b0, 1'b0);
    // full: retire two while allocation is still refused, then allocate at wrap
    step(2'b11, 2'b11, 1'b0, 1'b0);
    step(2'b11, 2'b00, 1'b0, 1'b0);
    step(2'b00, 2'b11, 1'b0, 1'b0);
    step(2'b00, 2'b11, 1'b0, 1'b0);
    step(2'b00, 2'b01, 1'b0, 1'b0);
    step(2'b00, 2'b10, 1'b0, 1'b0);
    step(2'b00, 2'b01, 1'b0, 1'b0);
    // flush with a non-empty ROB
    step(2'b11, 2'b11, 1'b1, 1'b0);
    step(2'b00, 2'b00, 1'b0, 1'b0);
    // drive tail to 7 and allocate across the wrap
    repeat (3) step(2'b11, 2'b00, 1'b0, 1'b0);
    step(2'b00, 2'b11, 1'b0, 1'b0);
    step(2'b00, 2'b11, 1'b0, 1'b0);
    step(2'b10, 2'b00, 1'b0, 1'b0);
    step(2'b00, 2'b01, 1'b0, 1'b0);
    step(2'b11, 2'b00, 1'b0, 1'b0);
    step(2'b00, 2'b11, 1'b0, 1'b0);
    step(2'b00, 2'b01, 1'b0, 1'b0);
    step(2'b00, 2'b11, 1'b0, 1'b0);
    step(2'b10, 2'b00, 1'b0, 1'b0);
    for (int n = 0; n < 2000; n++) begin
      step(2'($urandom), 2'($urandom), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 299) == 0));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
